mac_dot_acc: RTL and testbench

- Parametrised successor to the team's fixed 8-lane int8 MAC: LANES-wide dot product per beat, per-beat signed/unsigned mode, and a multi-beat accumulator for vectors longer than LANES.
- Fully pipelined with no backpressure; accepts one beat per cycle.
- Sits between the operand fetch and the requantisation stage of the inference datapath.

---
 rtl/mac_dot_acc_if.sv | 27 ++
 rtl/mac_dot_acc.sv | 127 ++++++++++++
 tb/tb_mac_dot_acc.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_acc_if.sv
// Beat and result bundle between operand fetch, the dot-product MAC and requantisation.
// The master drives beats in; the slave (the MAC) returns finished vector results.
interface mac_dot_acc_if #(
  parameter int LANES = 8,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
);
  logic                  i_valid;
  logic                  i_first;
  logic                  i_last;
  logic                  i_signed;
  logic [LANES*IN_W-1:0] i_a;
  logic [LANES*IN_W-1:0] i_b;
  logic                  o_valid;
  logic [ACC_W-1:0]      o_res;
  logic                  o_ovf;

  modport master (
    output i_valid, i_first, i_last, i_signed, i_a, i_b,
    input  o_valid, o_res, o_ovf
  );

  modport slave (
    input  i_valid, i_first, i_last, i_signed, i_a, i_b,
    output o_valid, o_res, o_ovf
  );
endinterface

// File: rtl/mac_dot_acc.sv
// LANES-wide dot-product MAC with per-beat signed/unsigned mode and a multi-beat
// accumulator; input register, multiply stage, LOG adder levels, accumulate stage.
module mac_dot_acc #(
  parameter int LANES = 8,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mac_dot_acc_if.slave bus
);
  localparam int LOG = $clog2(LANES);
  localparam int P_W = 2*IN_W + 1;
  localparam int S_W = P_W + LOG;

  if ((LANES < 2) || (LANES != (1 << LOG))) begin : g_bad_lanes
    $error("mac_dot_acc: LANES must be a power of 2 and at least 2");
  end
  if (ACC_W < S_W) begin : g_bad_acc_w
    $error("mac_dot_acc: ACC_W must be at least 2*IN_W+1+log2(LANES)");
  end

  // Operands are widened straight to the product width; the true product always fits.
  function automatic logic signed [P_W-1:0] lane_mul(input logic [IN_W-1:0] a,
                                                     input logic [IN_W-1:0] b,
                                                     input logic            sgn);
    logic signed [P_W-1:0] ea;
    logic signed [P_W-1:0] eb;
    ea = {{(IN_W+1){sgn & a[IN_W-1]}}, a};
    eb = {{(IN_W+1){sgn & b[IN_W-1]}}, b};
    return ea * eb;
  endfunction

  logic                  in_vld, in_fst, in_lst, in_sgn;
  logic [LANES*IN_W-1:0] in_a, in_b;

  always_ff @(posedge i_clk) begin
    // NOTE: only valid bits take reset; data and sideband are don't-care while valid is low.
    if (i_rst) in_vld <= 1'b0;
    else       in_vld <= bus.i_valid;
    in_fst <= bus.i_first;
    in_lst <= bus.i_last;
    in_sgn <= bus.i_signed;
    in_a   <= bus.i_a;
    in_b   <= bus.i_b;
  end

  // Level 0 holds the lane products; level lv holds LANES>>lv partial sums, one bit wider each level.
  for (genvar lv = 0; lv <= LOG; lv++) begin : g_lvl
    localparam int W = P_W + lv;
    localparam int N = LANES >> lv;
    logic signed [W-1:0] sum [N];
    logic                vld, fst, lst, sgn;

    if (lv == 0) begin : g_mul
      always_ff @(posedge i_clk) begin
        if (i_rst) vld <= 1'b0;
        else       vld <= in_vld;
        fst <= in_fst;
        lst <= in_lst;
        sgn <= in_sgn;
        for (int k = 0; k < N; k++)
          sum[k] <= lane_mul(in_a[k*IN_W +: IN_W], in_b[k*IN_W +: IN_W], in_sgn);
      end
    end else begin : g_add
      always_ff @(posedge i_clk) begin
        if (i_rst) vld <= 1'b0;
        else       vld <= g_lvl[lv-1].vld;
        fst <= g_lvl[lv-1].fst;
        lst <= g_lvl[lv-1].lst;
        sgn <= g_lvl[lv-1].sgn;
        for (int k = 0; k < N; k++)
          sum[k] <= {g_lvl[lv-1].sum[2*k][W-2],   g_lvl[lv-1].sum[2*k]}
                  + {g_lvl[lv-1].sum[2*k+1][W-2], g_lvl[lv-1].sum[2*k+1]};
      end
    end
  end

  logic signed [S_W-1:0]   top_sum;
  logic                    top_vld, top_fst, top_lst, top_sgn;
  logic signed [ACC_W-1:0] s_ext;
  logic [ACC_W:0]          acc_x, s_x, sum_x;
  logic [ACC_W-1:0]        acc, acc_nxt, res;
  logic                    ovf, ovf_nxt, res_ovf, res_vld, wrap;

  assign top_sum = g_lvl[LOG].sum[0];
  assign top_vld = g_lvl[LOG].vld;
  assign top_fst = g_lvl[LOG].fst;
  assign top_lst = g_lvl[LOG].lst;
  assign top_sgn = g_lvl[LOG].sgn;

  // The overflow test runs one bit wider than the accumulator, extended per this beat's mode.
  always_comb begin
    // NOTE: blocking assignments here; each intermediate is consumed later in this same block.
    s_ext   = ACC_W'(top_sum);
    acc_x   = {top_sgn & acc[ACC_W-1], acc};
    s_x     = {top_sgn & s_ext[ACC_W-1], s_ext};
    sum_x   = acc_x + s_x;
    wrap    = top_sgn ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
    acc_nxt = top_fst ? s_ext : sum_x[ACC_W-1:0];
    ovf_nxt = top_fst ? 1'b0 : (ovf | wrap);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= top_vld & top_lst;
      if (top_vld) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
        if (top_lst) begin
          res     <= acc_nxt;
          res_ovf <= ovf_nxt;
        end
      end
    end
  end

  assign bus.o_valid = res_vld;
  assign bus.o_res   = res;
  assign bus.o_ovf   = res_ovf;
endmodule

// File: tb/tb_mac_dot_acc.sv
// Bench for mac_dot_acc: a 32-bit and a 20-bit accumulator instance, directed scenarios
// plus randomized beats checked against an integer-arithmetic reference model.
module tb_mac_dot_acc;
  localparam int LAT = 5;

  typedef int lanes_t [8];
  typedef struct {
    int     cyc;
    longint res;
    bit     ovf;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t    got_q [2][$];
  ev_t    exp_q [2][$];
  longint m_acc [2];
  bit     m_ovf [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_acc_if #(.LANES(8), .IN_W(8), .ACC_W(32)) bus8 ();
  mac_dot_acc_if #(.LANES(8), .IN_W(8), .ACC_W(20)) bus20 ();

  mac_dot_acc #(.LANES(8), .IN_W(8), .ACC_W(32)) dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
  mac_dot_acc #(.LANES(8), .IN_W(8), .ACC_W(20)) dut20 (.i_clk(clk), .i_rst(rst), .bus(bus20));

  // Record every result pulse with the cycle it appeared in.
  always @(negedge clk) begin : rec
    ev_t e;
    if (bus8.o_valid === 1'b1) begin
      e.cyc = cyc; e.res = longint'(bus8.o_res); e.ovf = bus8.o_ovf;
      got_q[0].push_back(e);
    end
    if (bus20.o_valid === 1'b1) begin
      e.cyc = cyc; e.res = longint'(bus20.o_res); e.ovf = bus20.o_ovf;
      got_q[1].push_back(e);
    end
  end

  // Reference: exact dot product, accumulate modulo 2^W, overflow judged on the true sum.
  task automatic model(input int sel, input bit f, input bit l, input bit s,
                       input lanes_t a, input lanes_t b);
    int     w    = (sel == 0) ? 32 : 20;
    longint modv = longint'(1) << w;
    longint dot  = 0;
    longint t, sa;
    ev_t    e;
    for (int k = 0; k < 8; k++) begin
      int x = a[k] & 255;
      int y = b[k] & 255;
      if (s) begin
        if (x >= 128) x -= 256;
        if (y >= 128) y -= 256;
      end
      dot += longint'(x * y);
    end
    if (f) begin
      m_acc[sel] = dot & (modv - 1);
      m_ovf[sel] = 1'b0;
    end else begin
      if (s) begin
        sa = (m_acc[sel] >= modv / 2) ? m_acc[sel] - modv : m_acc[sel];
        t  = sa + dot;
        if (t < -(modv / 2) || t >= modv / 2) m_ovf[sel] = 1'b1;
      end else begin
        t = m_acc[sel] + dot;
        if (t >= modv) m_ovf[sel] = 1'b1;
      end
      m_acc[sel] = (m_acc[sel] + dot) & (modv - 1);
    end
    if (l) begin
      e.cyc = cyc + 1 + LAT; e.res = m_acc[sel]; e.ovf = m_ovf[sel];
      exp_q[sel].push_back(e);
    end
  endtask

  task automatic drive(input int sel, input bit v, input bit f, input bit l, input bit s,
                       input lanes_t a, input lanes_t b);
    logic [63:0] pa, pb;
    for (int k = 0; k < 8; k++) begin
      pa[k*8 +: 8] = a[k][7:0];
      pb[k*8 +: 8] = b[k][7:0];
    end
    @(negedge clk);
    bus8.i_valid  = (sel == 0) && v;
    bus20.i_valid = (sel == 1) && v;
    bus8.i_first  = f; bus8.i_last  = l; bus8.i_signed  = s; bus8.i_a  = pa; bus8.i_b  = pb;
    bus20.i_first = f; bus20.i_last = l; bus20.i_signed = s; bus20.i_a = pa; bus20.i_b = pb;
    if (v) model(sel, f, l, s, a, b);
  endtask

  // Idle cycles carry random junk on every qualified field.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus8.i_valid  = 1'b0;
      bus20.i_valid = 1'b0;
      bus8.i_first  = 1'($urandom); bus8.i_last  = 1'($urandom); bus8.i_signed  = 1'($urandom);
      bus20.i_first = 1'($urandom); bus20.i_last = 1'($urandom); bus20.i_signed = 1'($urandom);
      bus8.i_a  = {$urandom, $urandom}; bus8.i_b  = {$urandom, $urandom};
      bus20.i_a = {$urandom, $urandom}; bus20.i_b = {$urandom, $urandom};
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus8.i_valid  = 1'b0;
    bus20.i_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_ovf[s] = 1'b0;
      exp_q[s].delete();
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic lanes_t fill(input int v);
    lanes_t r;
    for (int k = 0; k < 8; k++) r[k] = v;
    return r;
  endfunction

  function automatic lanes_t rnd_lanes();
    lanes_t r;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 7))
        0:       r[k] = 128;
        1:       r[k] = 255;
        2:       r[k] = 0;
        default: r[k] = int'($urandom_range(0, 255));
      endcase
    end
    return r;
  endfunction

  task automatic clear_queues();
    for (int s = 0; s < 2; s++) begin
      got_q[s].delete();
      exp_q[s].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.i_valid = 1'b0;  bus8.i_first = 1'b0;  bus8.i_last = 1'b0;  bus8.i_signed = 1'b0;
    bus20.i_valid = 1'b0; bus20.i_first = 1'b0; bus20.i_last = 1'b0; bus20.i_signed = 1'b0;
    bus8.i_a = '0; bus8.i_b = '0; bus20.i_a = '0; bus20.i_b = '0;
    for (int s = 0; s < 2; s++) begin m_acc[s] = 0; m_ovf[s] = 1'b0; end
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus8.o_valid !== 1'b0)  begin errors++; $display("FAIL reset o_valid32: got %b, expected 0", bus8.o_valid); end
    if (bus8.o_res !== 32'd0)   begin errors++; $display("FAIL reset o_res32: got %0h, expected 0", bus8.o_res); end
    if (bus8.o_ovf !== 1'b0)    begin errors++; $display("FAIL reset o_ovf32: got %b, expected 0", bus8.o_ovf); end
    if (bus20.o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid20: got %b, expected 0", bus20.o_valid); end
    if (bus20.o_res !== 20'd0)  begin errors++; $display("FAIL reset o_res20: got %0h, expected 0", bus20.o_res); end
    if (bus20.o_ovf !== 1'b0)   begin errors++; $display("FAIL reset o_ovf20: got %b, expected 0", bus20.o_ovf); end
    rst = 1'b0;
    clear_queues();
    idle(2);
  endtask

  task automatic test_single(input string name, input bit s, input int v, input longint want);
    clear_queues();
    drive(0, 1, 1, 1, s, fill(v), fill(v));
    idle(10);
    checks++;
    if (got_q[0].size() !== 1) begin errors++; $display("FAIL %s count: got %0d pulses, expected 1", name, got_q[0].size()); end
    if (got_q[0].size() >= 1 && exp_q[0].size() >= 1) begin
      checks += 3;
      if (got_q[0][0].res !== want)         begin errors++; $display("FAIL %s res: got %0d, expected %0d", name, got_q[0][0].res, want); end
      if (got_q[0][0].ovf !== 1'b0)         begin errors++; $display("FAIL %s ovf: got %b, expected 0", name, got_q[0][0].ovf); end
      if (got_q[0][0].cyc !== exp_q[0][0].cyc) begin errors++; $display("FAIL %s latency: pulse at cycle %0d, expected %0d", name, got_q[0][0].cyc, exp_q[0][0].cyc); end
    end
    checks++;
    if (longint'(bus8.o_res) !== want) begin errors++; $display("FAIL %s hold: o_res %0d after pulse, expected %0d", name, bus8.o_res, want); end
  endtask

  task automatic test_multi_beat_gaps();
    lanes_t a;
    for (int k = 0; k < 8; k++) a[k] = k + 1;
    clear_queues();
    drive(0, 1, 1, 0, 1, a, fill(1));
    idle(2);
    drive(0, 1, 0, 0, 1, a, fill(1));
    idle(2);
    drive(0, 1, 0, 1, 1, a, fill(1));
    idle(10);
    checks++;
    if (got_q[0].size() !== 1) begin errors++; $display("FAIL gaps count: got %0d pulses, expected 1", got_q[0].size()); end
    if (got_q[0].size() >= 1 && exp_q[0].size() >= 1) begin
      checks += 3;
      if (got_q[0][0].res !== 108)   begin errors++; $display("FAIL gaps res: got %0d, expected 108", got_q[0][0].res); end
      if (got_q[0][0].ovf !== 1'b0)  begin errors++; $display("FAIL gaps ovf: got %b, expected 0", got_q[0][0].ovf); end
      if (got_q[0][0].cyc !== exp_q[0][0].cyc) begin errors++; $display("FAIL gaps latency: pulse at cycle %0d, expected %0d", got_q[0][0].cyc, exp_q[0][0].cyc); end
    end
  endtask

  task automatic test_overflow20();
    clear_queues();
    for (int i = 0; i < 4; i++) drive(1, 1, i == 0, i == 3, 1, fill(-128), fill(-128));
    drive(1, 1, 1, 1, 1, fill(1), fill(1));
    idle(10);
    checks++;
    if (got_q[1].size() !== 2) begin errors++; $display("FAIL ovf20 count: got %0d pulses, expected 2", got_q[1].size()); end
    if (got_q[1].size() >= 2) begin
      checks += 4;
      if (got_q[1][0].res !== 'h80000) begin errors++; $display("FAIL ovf20 res: got %0h, expected 80000", got_q[1][0].res); end
      if (got_q[1][0].ovf !== 1'b1)    begin errors++; $display("FAIL ovf20 ovf: got %b, expected 1", got_q[1][0].ovf); end
      if (got_q[1][1].res !== 8)       begin errors++; $display("FAIL ovf20 next res: got %0d, expected 8", got_q[1][1].res); end
      if (got_q[1][1].ovf !== 1'b0)    begin errors++; $display("FAIL ovf20 next ovf: got %b, expected 0", got_q[1][1].ovf); end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int n = 1; n <= 10; n++) drive(0, 1, 1, 1, 1, fill(n), fill(1));
    idle(10);
    checks++;
    if (got_q[0].size() !== 10) begin errors++; $display("FAIL b2b count: got %0d pulses, expected 10", got_q[0].size()); end
    for (int i = 0; i < got_q[0].size() && i < exp_q[0].size(); i++) begin
      checks += 3;
      if (got_q[0][i].res !== longint'(8 * (i + 1))) begin errors++; $display("FAIL b2b res[%0d]: got %0d, expected %0d", i, got_q[0][i].res, 8 * (i + 1)); end
      if (got_q[0][i].ovf !== 1'b0) begin errors++; $display("FAIL b2b ovf[%0d]: got %b, expected 0", i, got_q[0][i].ovf); end
      if (got_q[0][i].cyc !== exp_q[0][i].cyc) begin errors++; $display("FAIL b2b cycle[%0d]: got %0d, expected %0d", i, got_q[0][i].cyc, exp_q[0][i].cyc); end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    for (int i = 0; i < 3; i++) drive(0, 1, i == 0, 0, 1, fill(7), fill(9));
    reset_pulse();
    idle(10);
    checks += 4;
    if (got_q[0].size() !== 0) begin errors++; $display("FAIL rstmid pulses: got %0d, expected 0", got_q[0].size()); end
    if (bus8.o_res !== 32'd0)  begin errors++; $display("FAIL rstmid o_res: got %0h, expected 0", bus8.o_res); end
    if (bus8.o_ovf !== 1'b0)   begin errors++; $display("FAIL rstmid o_ovf: got %b, expected 0", bus8.o_ovf); end
    if (bus20.o_res !== 20'd0) begin errors++; $display("FAIL rstmid o_res20: got %0h, expected 0", bus20.o_res); end
    clear_queues();
    drive(0, 1, 1, 1, 0, fill(3), fill(5));
    idle(10);
    checks++;
    if (got_q[0].size() !== 1) begin errors++; $display("FAIL rstmid fresh count: got %0d pulses, expected 1", got_q[0].size()); end
    if (got_q[0].size() >= 1 && exp_q[0].size() >= 1) begin
      checks += 2;
      if (got_q[0][0].res !== 120) begin errors++; $display("FAIL rstmid fresh res: got %0d, expected 120", got_q[0][0].res); end
      if (got_q[0][0].cyc !== exp_q[0][0].cyc) begin errors++; $display("FAIL rstmid fresh latency: pulse at cycle %0d, expected %0d", got_q[0][0].cyc, exp_q[0][0].cyc); end
    end
  endtask

  task automatic test_random(input int sel, input int n);
    clear_queues();
    drive(sel, 1, 1, 0, 1'($urandom), rnd_lanes(), rnd_lanes());
    for (int i = 0; i < n; i++)
      drive(sel, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom), rnd_lanes(), rnd_lanes());
    idle(12);
    checks++;
    if (got_q[sel].size() !== exp_q[sel].size()) begin
      errors++;
      $display("FAIL random%0d count: got %0d pulses, expected %0d", sel, got_q[sel].size(), exp_q[sel].size());
    end
    for (int i = 0; i < got_q[sel].size() && i < exp_q[sel].size(); i++) begin
      checks++;
      if (got_q[sel][i].cyc !== exp_q[sel][i].cyc || got_q[sel][i].res !== exp_q[sel][i].res ||
          got_q[sel][i].ovf !== exp_q[sel][i].ovf) begin
        errors++;
        $display("FAIL random%0d[%0d]: got cyc=%0d res=%0h ovf=%b, expected cyc=%0d res=%0h ovf=%b",
                 sel, i, got_q[sel][i].cyc, got_q[sel][i].res, got_q[sel][i].ovf,
                 exp_q[sel][i].cyc, exp_q[sel][i].res, exp_q[sel][i].ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single("single_signed", 1'b1, -128, 131072);
    test_single("single_unsigned", 1'b0, 255, 520200);
    test_multi_beat_gaps();
    test_overflow20();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 200);
    test_random(1, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
